mem_responder: RTL and testbench

Word-addressed memory target that answers the rotate-and-write initiator on the shared `addr`/`data`/`wr_en` bus. It holds DEPTH 32-bit words at byte addresses 0, 4, … 4·(DEPTH−1) and returns read data combinationally, so the initiator can sample it in the same cycle it drives the address. Writes commit on the clock edge. The block also keeps a saturating write counter and a sticky error capture for illegal accesses, for system-level checking.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_addr_check.sv | 29 ++
 rtl/mem_responder.sv | 94 +++++++++
 tb/tb_mem_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the word-addressed memory responder.
package mem_pkg;

  // Reset pattern seed: word i resets to INIT_WORD * (i + 1), low 32 bits kept.
  localparam logic [31:0] INIT_WORD = 32'h1111_1111;

  // Reset value of word i.
  function automatic logic [31:0] init_val(input int i);
    logic [31:0] mult_s;
    mult_s = 32'(i + 1);
    return INIT_WORD * mult_s;
  endfunction

  // Width of a word index for a memory of 'depth' words, never below 1 bit.
  function automatic int idx_w(input int depth);
    int w_s;
    w_s = $clog2(depth);
    if (w_s < 1) begin
      w_s = 1;
    end else begin
      w_s = w_s;
    end
    return w_s;
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Decodes a byte address into a word index and flags misaligned or
// out-of-range addresses. Purely combinational.
module mem_addr_check
  import mem_pkg::*;
#(
  parameter int DEPTH = 5
) (
  input  logic [31:0]               addr,
  output logic                      legal,
  output logic [idx_w(DEPTH)-1:0]   idx
);

  localparam int          IW      = idx_w(DEPTH);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  // Full 30-bit range compare so high address bits can never alias a low word.
  always_comb begin
    legal = 1'b0;
    idx   = '0;
    if ((addr[1:0] == 2'b00) && (addr[31:2] < DEPTH_W)) begin
      legal = 1'b1;
      idx   = addr[IW+1:2];
    end else begin
      legal = 1'b0;
      idx   = '0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory target: combinational read, clocked write,
// saturating count of accepted writes and a sticky first-error capture.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             wr_en,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [CNT_W-1:0] wr_count,
  output logic             err,
  output logic [31:0]      err_addr
);

  localparam int               IW      = idx_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             legal_s;
  logic [IW-1:0]    idx_s;
  logic [31:0]      rdata_s;
  logic [31:0]      mem_r [DEPTH];
  logic [CNT_W-1:0] wr_count_r;
  logic             err_r;
  logic [31:0]      err_addr_r;

  mem_addr_check #(
    .DEPTH (DEPTH)
  ) u_addr_check (
    .addr  (addr),
    .legal (legal_s),
    .idx   (idx_s)
  );

  // Storage: reset to the init pattern, otherwise commit legal writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= init_val(i);
      end
    end else if (wr_en && legal_s) begin
      mem_r[idx_s] <= wdata;
    end
  end

  // Count accepted writes, holding at the maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_r <= '0;
    end else if (wr_en && legal_s && (wr_count_r != CNT_MAX)) begin
      wr_count_r <= wr_count_r + CNT_W'(1);
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  // Sticky error flag; only the first illegal write address is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r      <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else if (wr_en && !legal_s) begin
      err_r <= 1'b1;
      if (!err_r) begin
        err_addr_r <= addr;
      end else begin
        err_addr_r <= err_addr_r;
      end
    end else begin
      err_r      <= err_r;
      err_addr_r <= err_addr_r;
    end
  end

  // Zero-latency read so the initiator can sample in its address cycle.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (legal_s) begin
      rdata_s = mem_r[idx_s];
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign rdata    = rdata_s;
  assign wr_count = wr_count_r;
  assign err      = err_r;
  assign err_addr = err_addr_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a behavioural memory model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_mem_responder;

  localparam int DEPTH = 5;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        wr_en;
  logic [31:0] wdata;

  logic [31:0] rdata;
  logic [15:0] wr_count;
  logic        err;
  logic [31:0] err_addr;

  logic [31:0] rdata_sat;
  logic [2:0]  wr_count_sat;
  logic        err_sat;
  logic [31:0] err_addr_sat;

  int n_chk;
  int n_fail;
  bit check_en;

  // behavioural model state
  logic [31:0] m_mem [DEPTH];
  int          m_writes;
  logic        m_err;
  logic [31:0] m_err_addr;

  mem_responder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wdata(wdata),
    .rdata(rdata), .wr_count(wr_count), .err(err), .err_addr(err_addr)
  );

  mem_responder #(.DEPTH(DEPTH), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wdata(wdata),
    .rdata(rdata_sat), .wr_count(wr_count_sat), .err(err_sat), .err_addr(err_addr_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit addr_ok(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && ((a / 32'd4) < 32'(DEPTH));
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (addr_ok(a)) return m_mem[a / 32'd4];
    return 32'h0;
  endfunction

  function automatic int sat_at(input int n, input int maxv);
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: applies the spec's write / error / reset rules at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'h1111_1111 * 32'(i + 1);
      m_writes   <= 0;
      m_err      <= 1'b0;
      m_err_addr <= 32'h0;
    end else if (wr_en) begin
      if (addr_ok(addr)) begin
        m_mem[addr / 32'd4] <= wdata;
        m_writes            <= m_writes + 1;
      end else begin
        m_err <= 1'b1;
        if (!m_err) m_err_addr <= addr;
      end
    end
  end

  // Compare both DUT instances against the model every cycle, mid-period.
  always @(negedge clk) begin
    if (check_en) begin
      chk("rdata",        rdata,               model_read(addr));
      chk("wr_count",     32'(wr_count),       32'(sat_at(m_writes, 65535)));
      chk("err",          32'(err),            32'(m_err));
      chk("err_addr",     err_addr,            m_err_addr);
      chk("sat_rdata",    rdata_sat,           model_read(addr));
      chk("sat_wr_count", 32'(wr_count_sat),   32'(sat_at(m_writes, 7)));
      chk("sat_err",      32'(err_sat),        32'(m_err));
      chk("sat_err_addr", err_addr_sat,        m_err_addr);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    rst = r; wr_en = w; addr = a; wdata = d;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] lit [5];
  logic [31:0] x;

  initial begin
    n_chk = 0; n_fail = 0; check_en = 1'b0;
    lit[0] = 32'h1111_1111; lit[1] = 32'h2222_2222; lit[2] = 32'h3333_3333;
    lit[3] = 32'h4444_4444; lit[4] = 32'h5555_5555;
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    advance();
    advance();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    check_en = 1'b1;

    // reset image sweep
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'(4 * k), 32'h0);
      @(negedge clk);
      chk("init_sweep", rdata, lit[k]);
      advance();
    end
    @(negedge clk);
    chk("init_count", 32'(wr_count), 32'h0);
    chk("init_err",   32'(err),      32'h0);
    advance();

    // initiator loop: read, then write rotated value next cycle
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'(4 * k), 32'h0);
      advance();
      x = lit[k];
      drive(1'b0, 1'b1, 32'(4 * k), {x[30:0], x[31]});
      advance();
    end
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    @(negedge clk);
    chk("rot_addr0", rdata, 32'h2222_2222);
    chk("rot_count", 32'(wr_count), 32'd5);
    advance();
    drive(1'b0, 1'b0, 32'd16, 32'h0);
    @(negedge clk);
    chk("rot_addr16", rdata, 32'hAAAA_AAAA);
    advance();

    // fresh image, then same-cycle read during write
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    advance();
    drive(1'b0, 1'b1, 32'd8, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rw_old", rdata, 32'h3333_3333);
    advance();
    drive(1'b0, 1'b0, 32'd8, 32'h0);
    @(negedge clk);
    chk("rw_new", rdata, 32'hDEAD_BEEF);
    advance();

    // illegal accesses
    drive(1'b0, 1'b1, 32'd20, 32'h1234_5678);
    advance();
    drive(1'b0, 1'b0, 32'd20, 32'h0);
    @(negedge clk);
    chk("ill_err",      32'(err),      32'h1);
    chk("ill_err_addr", err_addr,      32'd20);
    chk("ill_count",    32'(wr_count), 32'd1);
    chk("ill_read20",   rdata,         32'h0);
    advance();
    drive(1'b0, 1'b1, 32'd6, 32'hCAFE_F00D);
    advance();
    drive(1'b0, 1'b1, 32'h4000_0000, 32'hBAD0_BAD0);
    advance();
    drive(1'b0, 1'b0, 32'd6, 32'h0);
    @(negedge clk);
    chk("ill_keep_first", err_addr, 32'd20);
    chk("ill_read6",      rdata,    32'h0);
    advance();
    drive(1'b0, 1'b0, 32'd4, 32'h0);
    @(negedge clk);
    chk("ill_word1_intact", rdata, 32'h2222_2222);
    advance();
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    @(negedge clk);
    chk("ill_word0_intact", rdata, 32'h1111_1111);
    advance();

    // back-to-back writes, saturating the 3-bit counter
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b1, 32'd12, 32'hA000_0000 + 32'(k));
      advance();
    end
    drive(1'b0, 1'b0, 32'd12, 32'h0);
    @(negedge clk);
    chk("sat_count7",  32'(wr_count_sat), 32'd7);
    chk("sat_last",    rdata_sat,         32'hA000_0009);
    chk("wide_count",  32'(wr_count),     32'd11);
    advance();

    // reset wins over a simultaneous write
    drive(1'b1, 1'b1, 32'd0, 32'h0);
    advance();
    drive(1'b0, 1'b0, 32'd0, 32'h0);
    @(negedge clk);
    chk("rstpri_addr0", rdata,         32'h1111_1111);
    chk("rstpri_count", 32'(wr_count), 32'h0);
    chk("rstpri_err",   32'(err),      32'h0);
    chk("rstpri_eaddr", err_addr,      32'h0);
    advance();
    drive(1'b0, 1'b0, 32'd12, 32'h0);
    @(negedge clk);
    chk("rstpri_addr12", rdata, 32'h4444_4444);
    advance();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
